// File: rtl/riscv_pkg.sv
// Shared types and constants for the issue queue: entry record, issue record,
// bypass bus field offsets and the branch-mask hit helper.
package riscv_pkg;

  localparam int UOP_W  = 7;
  localparam int CTRL_W = 6;
  localparam int BRM_W  = 4;
  localparam int PRD_W  = 7;

  // Bypass bus layout: {valid, pdst, data[31:0]}
  localparam int BYP_VALID  = 32 + PRD_W;
  localparam int BYP_TAG_HI = 31 + PRD_W;
  localparam int BYP_TAG_LO = 32;

  typedef struct packed {
    logic              valid;
    logic [UOP_W-1:0]  uop;
    logic [CTRL_W-1:0] ctrl;
    logic [BRM_W-1:0]  brmask;
    logic [31:0]       pc;
    logic [31:0]       imm;
    logic [PRD_W-1:0]  prs1;
    logic [PRD_W-1:0]  prs2;
    logic              rdy1;
    logic              rdy2;
    logic [PRD_W-1:0]  pdst;
  } iq_entry_t;

  typedef struct packed {
    logic              valid;
    logic [UOP_W-1:0]  uop;
    logic [CTRL_W-1:0] ctrl;
    logic [BRM_W-1:0]  brmask;
    logic [31:0]       pc;
    logic [31:0]       imm;
    logic [PRD_W-1:0]  prs1;
    logic [PRD_W-1:0]  prs2;
    logic [PRD_W-1:0]  pdst;
  } iq_issue_t;

  function automatic logic br_hit(input logic [BRM_W-1:0] mask,
                                  input logic [BRM_W-1:0] kill);
    return |(mask & kill);
  endfunction

endpackage

// File: rtl/iq_select.sv
// Priority encoder: returns the lowest set request index and a found flag.
module iq_select #(
  parameter int DEPTH = 8
) (
  input  logic [DEPTH-1:0]         req_i,
  output logic [$clog2(DEPTH)-1:0] idx_o,
  output logic                     found_o
);

  localparam int IW = $clog2(DEPTH);

  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o   = IW'(i);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/issue_queue.sv
// Collapsing out-of-order issue queue with oldest-ready select and branch-mask squash.
// Define ISSUE_QUEUE_FAST_WAKEUP_EN to let a bypass match feed select in the same cycle.
module issue_queue
  import riscv_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int WIDTH_BRM = BRM_W,
  parameter int WIDTH_PRD = PRD_W
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_disp_valid,
  output logic                     o_disp_ready,
  input  logic [UOP_W-1:0]         i_disp_uop,
  input  logic [CTRL_W-1:0]        i_disp_ctrl,
  input  logic [WIDTH_BRM-1:0]     i_disp_brmask,
  input  logic [31:0]              i_disp_pc,
  input  logic [31:0]              i_disp_imm,
  input  logic [WIDTH_PRD-1:0]     i_disp_prs1,
  input  logic [WIDTH_PRD-1:0]     i_disp_prs2,
  input  logic                     i_disp_rdy1,
  input  logic                     i_disp_rdy2,
  input  logic [WIDTH_PRD-1:0]     i_disp_pdst,
  input  logic [32+WIDTH_PRD:0]    i_bypass,
  input  logic [WIDTH_BRM-1:0]     i_br_kill,
  input  logic [WIDTH_BRM-1:0]     i_br_clr,
  output logic                     o_iss_valid,
  input  logic                     i_iss_ready,
  output logic [UOP_W-1:0]         o_iss_uop,
  output logic [CTRL_W-1:0]        o_iss_ctrl,
  output logic [WIDTH_BRM-1:0]     o_iss_brmask,
  output logic [31:0]              o_iss_pc,
  output logic [31:0]              o_iss_imm,
  output logic [WIDTH_PRD-1:0]     o_iss_prs1,
  output logic [WIDTH_PRD-1:0]     o_iss_prs2,
  output logic [WIDTH_PRD-1:0]     o_iss_pdst,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;

  iq_entry_t        ent_q [DEPTH];
  iq_entry_t        ent_d [DEPTH];
  iq_entry_t        woke  [DEPTH];
  iq_issue_t        iss_q, iss_d;
  logic [CW-1:0]    count_q, count_d, cnt;

  logic             byp_v;
  logic [PRD_W-1:0] byp_tag;
  logic [DEPTH-1:0] alive, sel_req, keep;
  logic [IW-1:0]    sel_idx;
  logic             sel_found, sel_go, iss_take, disp_ok;
  iq_entry_t        disp_e;
  logic             unused_byp_data;

  assign byp_v           = i_bypass[BYP_VALID];
  assign byp_tag         = i_bypass[BYP_TAG_HI:BYP_TAG_LO];
  assign unused_byp_data = ^i_bypass[31:0];

  assign o_disp_ready = (count_q < CW'(DEPTH));
  assign iss_take     = ~iss_q.valid | i_iss_ready;
  assign sel_go       = iss_take & sel_found;
  assign disp_ok      = i_disp_valid & o_disp_ready & ~br_hit(i_disp_brmask, i_br_kill);

  // Entries as they will look after this edge's wakeup and clear; alive excludes kills.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      woke[i]        = ent_q[i];
      woke[i].rdy1   = ent_q[i].rdy1 | (byp_v & (ent_q[i].prs1 == byp_tag));
      woke[i].rdy2   = ent_q[i].rdy2 | (byp_v & (ent_q[i].prs2 == byp_tag));
      woke[i].brmask = ent_q[i].brmask & ~i_br_clr;
      alive[i]       = ent_q[i].valid & ~br_hit(ent_q[i].brmask, i_br_kill);
`ifdef ISSUE_QUEUE_FAST_WAKEUP_EN
      sel_req[i]     = alive[i] & woke[i].rdy1 & woke[i].rdy2;
`else
      sel_req[i]     = alive[i] & ent_q[i].rdy1 & ent_q[i].rdy2;
`endif
    end
  end

  // Entries squashed this cycle are never offered to select.
  iq_select #(.DEPTH(DEPTH)) u_sel (
    .req_i   (sel_req),
    .idx_o   (sel_idx),
    .found_o (sel_found)
  );

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      keep[i] = alive[i] & ~(sel_go & (sel_idx == IW'(i)));
    end
  end

  always_comb begin
    disp_e        = '0;
    disp_e.valid  = 1'b1;
    disp_e.uop    = i_disp_uop;
    disp_e.ctrl   = i_disp_ctrl;
    disp_e.brmask = i_disp_brmask & ~i_br_clr;
    disp_e.pc     = i_disp_pc;
    disp_e.imm    = i_disp_imm;
    disp_e.prs1   = i_disp_prs1;
    disp_e.prs2   = i_disp_prs2;
    disp_e.rdy1   = i_disp_rdy1 | (byp_v & (i_disp_prs1 == byp_tag));
    disp_e.rdy2   = i_disp_rdy2 | (byp_v & (i_disp_prs2 == byp_tag));
    disp_e.pdst   = i_disp_pdst;
  end

  always_comb begin
    iss_d        = iss_q;
    iss_d.brmask = iss_q.brmask & ~i_br_clr;
    if (br_hit(iss_q.brmask, i_br_kill)) begin
      iss_d.valid = 1'b0;
    end
    if (iss_take) begin
      iss_d.valid = sel_go;
      if (sel_go) begin
        iss_d.uop    = woke[sel_idx].uop;
        iss_d.ctrl   = woke[sel_idx].ctrl;
        iss_d.brmask = woke[sel_idx].brmask;
        iss_d.pc     = woke[sel_idx].pc;
        iss_d.imm    = woke[sel_idx].imm;
        iss_d.prs1   = woke[sel_idx].prs1;
        iss_d.prs2   = woke[sel_idx].prs2;
        iss_d.pdst   = woke[sel_idx].pdst;
      end
    end
  end

  // Compaction: survivors keep their relative order; dispatch appends after them.
  always_comb begin
    cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i] = '0;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (keep[i]) begin
        ent_d[cnt[IW-1:0]] = woke[i];
        cnt = cnt + 1'b1;
      end
    end
    if (disp_ok) begin
      ent_d[cnt[IW-1:0]] = disp_e;
    end
    count_d = cnt + CW'(disp_ok);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
      iss_q   <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= ent_d[i];
      end
      iss_q   <= iss_d;
      count_q <= count_d;
    end
  end

  assign o_iss_valid  = iss_q.valid;
  assign o_iss_uop    = iss_q.uop;
  assign o_iss_ctrl   = iss_q.ctrl;
  assign o_iss_brmask = iss_q.brmask;
  assign o_iss_pc     = iss_q.pc;
  assign o_iss_imm    = iss_q.imm;
  assign o_iss_prs1   = iss_q.prs1;
  assign o_iss_prs2   = iss_q.prs2;
  assign o_iss_pdst   = iss_q.pdst;
  assign o_count      = count_q;

endmodule

// File: tb/tb_issue_queue.sv
// Self-checking bench for issue_queue: directed scenarios plus randomized traffic
// compared cycle by cycle against a queue-based reference model.
module tb_issue_queue;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        disp_valid, disp_ready;
  logic [6:0]  disp_uop;
  logic [5:0]  disp_ctrl;
  logic [3:0]  disp_brmask;
  logic [31:0] disp_pc, disp_imm;
  logic [6:0]  disp_prs1, disp_prs2, disp_pdst;
  logic        disp_rdy1, disp_rdy2;
  logic [39:0] bypass;
  logic [3:0]  br_kill, br_clr;
  logic        iss_valid, iss_ready;
  logic [6:0]  iss_uop;
  logic [5:0]  iss_ctrl;
  logic [3:0]  iss_brmask;
  logic [31:0] iss_pc, iss_imm;
  logic [6:0]  iss_prs1, iss_prs2, iss_pdst;
  logic [3:0]  count;

  int n_chk = 0;
  int n_err = 0;

  issue_queue #(.DEPTH(DEPTH), .WIDTH_BRM(4), .WIDTH_PRD(7)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_disp_valid(disp_valid), .o_disp_ready(disp_ready),
    .i_disp_uop(disp_uop), .i_disp_ctrl(disp_ctrl), .i_disp_brmask(disp_brmask),
    .i_disp_pc(disp_pc), .i_disp_imm(disp_imm),
    .i_disp_prs1(disp_prs1), .i_disp_prs2(disp_prs2),
    .i_disp_rdy1(disp_rdy1), .i_disp_rdy2(disp_rdy2), .i_disp_pdst(disp_pdst),
    .i_bypass(bypass), .i_br_kill(br_kill), .i_br_clr(br_clr),
    .o_iss_valid(iss_valid), .i_iss_ready(iss_ready),
    .o_iss_uop(iss_uop), .o_iss_ctrl(iss_ctrl), .o_iss_brmask(iss_brmask),
    .o_iss_pc(iss_pc), .o_iss_imm(iss_imm),
    .o_iss_prs1(iss_prs1), .o_iss_prs2(iss_prs2), .o_iss_pdst(iss_pdst),
    .o_count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  uop;
    logic [5:0]  ctrl;
    logic [3:0]  brm;
    logic [31:0] pc, imm;
    logic [6:0]  prs1, prs2, pdst;
    bit          r1, r2;
  } mop_t;

  mop_t mq[$];
  mop_t miss;
  bit   miss_v;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit killed(input logic [3:0] m);
    return (m & br_kill) != 4'b0;
  endfunction

  function automatic bit wake(input logic [6:0] t);
    return bypass[39] && (bypass[38:32] == t);
  endfunction

  function automatic bit can_issue(input mop_t e);
`ifdef ISSUE_QUEUE_FAST_WAKEUP_EN
    return (e.r1 || wake(e.prs1)) && (e.r2 || wake(e.prs2));
`else
    return e.r1 && e.r2;
`endif
  endfunction

  task automatic model_reset();
    mq.delete();
    miss   = '{default: '0};
    miss_v = 0;
  endtask

  // Reference: next queue/issue state from the current inputs, evaluated just before the edge.
  task automatic model_next();
    mop_t nq[$];
    mop_t e;
    int   sel  = -1;
    bit   take = !miss_v || iss_ready;
    if (take) begin
      foreach (mq[k]) if (sel < 0 && !killed(mq[k].brm) && can_issue(mq[k])) sel = k;
    end
    if (take) begin
      if (sel >= 0) begin
        miss     = mq[sel];
        miss.brm = miss.brm & ~br_clr;
        miss_v   = 1;
      end else begin
        miss_v = 0;
      end
    end else begin
      if (killed(miss.brm)) miss_v = 0;
      miss.brm = miss.brm & ~br_clr;
    end
    foreach (mq[k]) begin
      if (k != sel && !killed(mq[k].brm)) begin
        e     = mq[k];
        e.r1  = e.r1 || wake(e.prs1);
        e.r2  = e.r2 || wake(e.prs2);
        e.brm = e.brm & ~br_clr;
        nq.push_back(e);
      end
    end
    if (disp_valid && mq.size() < DEPTH && !killed(disp_brmask)) begin
      e.uop  = disp_uop;   e.ctrl = disp_ctrl;  e.brm = disp_brmask & ~br_clr;
      e.pc   = disp_pc;    e.imm  = disp_imm;
      e.prs1 = disp_prs1;  e.prs2 = disp_prs2;  e.pdst = disp_pdst;
      e.r1   = disp_rdy1 || wake(disp_prs1);
      e.r2   = disp_rdy2 || wake(disp_prs2);
      nq.push_back(e);
    end
    mq = nq;
  endtask

  task automatic check_all();
    chk("count", 128'(count), 128'(mq.size()));
    chk("iss_valid", 128'(iss_valid), 128'(miss_v));
    chk("disp_ready", 128'(disp_ready), 128'(mq.size() < DEPTH));
    if (miss_v)
      chk("iss_fields",
          128'({iss_uop, iss_ctrl, iss_brmask, iss_pc, iss_imm, iss_prs1, iss_prs2, iss_pdst}),
          128'({miss.uop, miss.ctrl, miss.brm, miss.pc, miss.imm, miss.prs1, miss.prs2, miss.pdst}));
  endtask

  task automatic step();
    model_next();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle();
    disp_valid = 0; bypass = '0; br_kill = '0; br_clr = '0;
  endtask

  task automatic set_disp(input logic [6:0] pdst, input logic [6:0] prs1, input logic [6:0] prs2,
                          input bit r1, input bit r2, input logic [3:0] brm);
    disp_valid  = 1;
    disp_uop    = 7'($urandom);
    disp_ctrl   = 6'($urandom);
    disp_brmask = brm;
    disp_pc     = $urandom;
    disp_imm    = $urandom;
    disp_prs1   = prs1;
    disp_prs2   = prs2;
    disp_pdst   = pdst;
    disp_rdy1   = r1;
    disp_rdy2   = r2;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_valid"}, 128'(iss_valid), 128'(0));
    chk({tag, "_count"}, 128'(count), 128'(0));
    chk({tag, "_ready"}, 128'(disp_ready), 128'(1));
    chk({tag, "_fields"},
        128'({iss_uop, iss_ctrl, iss_brmask, iss_pc, iss_imm, iss_prs1, iss_prs2, iss_pdst}),
        128'(0));
  endtask

  initial begin
    rst = 1'b1;
    idle();
    set_disp(0, 0, 0, 0, 0, 0);
    disp_valid = 0;
    iss_ready  = 1;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_state("reset");
    #2 rst = 1'b0;
    model_reset();

    // Ordering: A then B, both ready
    set_disp(7'd5, 0, 0, 1, 1, 4'b0); step();
    set_disp(7'd6, 0, 0, 1, 1, 4'b0); step();
    chk("ord_A", 128'(iss_pdst), 128'(5));
    idle(); step();
    chk("ord_B", 128'(iss_pdst), 128'(6));
    step(); step();

    // Wakeup via bypass two cycles after dispatch
    set_disp(7'd12, 7'd9, 7'd3, 0, 1, 4'b0); step();
    idle(); step();
    bypass = {1'b1, 7'd9, 32'hDEAD_BEEF}; step();
    bypass = '0;
`ifdef ISSUE_QUEUE_FAST_WAKEUP_EN
    chk("wake_fast_v", 128'(iss_valid), 128'(1));
    chk("wake_fast_pd", 128'(iss_pdst), 128'(12));
`else
    chk("wake_n1_v", 128'(iss_valid), 128'(0));
    step();
    chk("wake_n2_v", 128'(iss_valid), 128'(1));
    chk("wake_n2_pd", 128'(iss_pdst), 128'(12));
`endif
    step(); step();

    // Full with backpressure, then drain in order
    iss_ready = 0;
    for (int k = 0; k < DEPTH + 2; k++) begin
      set_disp(7'(20 + k), 0, 0, 1, 1, 4'b0); step();
      if (k >= 1) chk("full_hold", 128'(iss_pdst), 128'(20));
    end
    idle();
    chk("full_count", 128'(count), 128'(DEPTH));
    chk("full_ready", 128'(disp_ready), 128'(0));
    iss_ready = 1;
    for (int k = 0; k < DEPTH; k++) begin
      step();
      chk("drain_order", 128'(iss_pdst), 128'(21 + k));
    end
    step();
    chk("drain_empty", 128'(iss_valid), 128'(0));

    // Kill: entries 0001/0010/0011, issue register 0001
    iss_ready = 0;
    set_disp(7'd40, 0, 0, 1, 1, 4'b0001); step();
    set_disp(7'd41, 0, 0, 1, 1, 4'b0001); step();
    set_disp(7'd42, 0, 0, 1, 1, 4'b0010); step();
    set_disp(7'd43, 0, 0, 1, 1, 4'b0011); step();
    idle();
    chk("kill_pre_cnt", 128'(count), 128'(3));
    br_kill = 4'b0001; step(); br_kill = '0;
    chk("kill_cnt", 128'(count), 128'(1));
    chk("kill_issv", 128'(iss_valid), 128'(0));

    // Clear alone, then kill and clear on the same bit
    br_clr = 4'b0010; step(); br_clr = '0;
    chk("clr_pd", 128'(iss_pdst), 128'(42));
    chk("clr_brm", 128'(iss_brmask), 128'(0));
    set_disp(7'd44, 0, 0, 1, 1, 4'b0100); step();
    idle();
    br_kill = 4'b0100; br_clr = 4'b0100; step(); idle();
    chk("killclr_cnt", 128'(count), 128'(0));
    chk("killclr_iss", 128'(iss_pdst), 128'(42));
    iss_ready = 1;
    step(); step();

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      idle();
      if ($urandom_range(0, 9) < 6)
        set_disp(7'($urandom), 7'($urandom_range(0, 15)), 7'($urandom_range(0, 15)),
                 bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                 ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0);
      if ($urandom_range(0, 9) < 4)
        bypass = {1'b1, 7'($urandom_range(0, 15)), 32'($urandom)};
      if ($urandom_range(0, 19) == 0) br_kill = 4'(1 << $urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0)  br_clr  = 4'(1 << $urandom_range(0, 3));
      iss_ready = ($urandom_range(0, 9) < 7);
      step();
    end

    // Asynchronous reset in the middle of a cycle with traffic pending
    idle();
    iss_ready = 0;
    for (int k = 0; k < 3; k++) begin
      set_disp(7'(60 + k), 0, 0, 1, 1, 4'b0); step();
    end
    idle();
    #2 rst = 1'b1;
    #1 chk_reset_state("midrst");
    #1 rst = 1'b0;
    model_reset();
    iss_ready = 1;
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
